// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - per-request control FSM for the direct-mapped cache
// Optional: define CACHE_CTRL_PERF_CNT_EN to build the hit/miss performance counters.
module cache_controller #(
  parameter int SET_SIZE  = 2,
  parameter int TAG_SIZE  = 30,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [TAG_SIZE-1:0] req_tag,
  output logic                req_ready,
  output logic                req_done,
  input  logic                valid_block_match,
  input  logic                valid_dirty_bit,
  input  logic [TAG_SIZE-1:0] selected_tag,
  output logic                clear_selected_valid_bit,
  output logic                finish_new_line_install,
  output logic                set_selected_dirty_bit,
  output logic                clear_selected_dirty_bit,
  output logic                cpu_data_we,
  output logic                fill_data_we,
  output logic                mem_req_valid,
  output logic                mem_req_write,
  output logic [TAG_SIZE-1:0] mem_req_tag,
  input  logic                mem_resp_valid,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  if (SET_SIZE < 1 || TAG_SIZE < 1) begin : g_bad_cfg
    $error("cache_controller: SET_SIZE and TAG_SIZE must be positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_FILL} state_t;

  state_t r_state;
  logic   r_write;
  logic   r_req_ready;
  logic   r_mem_req_valid;
  logic   r_mem_req_write;

  logic   w_hit;
  logic   w_miss;
  logic   w_wb_done;
  logic   w_fill_done;

  assign w_hit       = (r_state == S_COMPARE) && valid_block_match;
  assign w_miss      = (r_state == S_COMPARE) && !valid_block_match;
  assign w_wb_done   = (r_state == S_WRITEBACK) && mem_resp_valid;
  assign w_fill_done = (r_state == S_FILL) && mem_resp_valid;

  // After a fill the FSM re-enters COMPARE; the re-lookup hits and completes the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_write         <= 1'b0;
      r_req_ready     <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_mem_req_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state     <= S_COMPARE;
            r_write     <= req_write && !READ_ONLY;
            r_req_ready <= 1'b0;
          end
        end
        S_COMPARE: begin
          if (valid_block_match) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end else if (valid_dirty_bit && !READ_ONLY) begin
            r_state         <= S_WRITEBACK;
            r_mem_req_valid <= 1'b1;
            r_mem_req_write <= 1'b1;
          end else begin
            r_state         <= S_FILL;
            r_mem_req_valid <= 1'b1;
            r_mem_req_write <= 1'b0;
          end
        end
        S_WRITEBACK: begin
          if (mem_resp_valid) begin
            r_state         <= S_FILL;
            r_mem_req_write <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_resp_valid) begin
            r_state         <= S_COMPARE;
            r_mem_req_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready                = r_req_ready;
  assign req_done                 = w_hit;
  assign set_selected_dirty_bit   = READ_ONLY ? 1'b0 : (w_hit && r_write);
  assign cpu_data_we              = READ_ONLY ? 1'b0 : (w_hit && r_write);
  assign clear_selected_dirty_bit = READ_ONLY ? 1'b0 : w_wb_done;
  assign clear_selected_valid_bit = w_wb_done;
  assign fill_data_we             = w_fill_done;
  assign finish_new_line_install  = w_fill_done;
  assign mem_req_valid            = r_mem_req_valid;
  assign mem_req_write            = r_mem_req_write;
  assign mem_req_tag              = !r_mem_req_valid ? '0 :
                                    (r_mem_req_write ? selected_tag : req_tag);

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic        r_retry;
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // The retry flag keeps the post-fill re-lookup from counting as a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retry      <= 1'b0;
      r_hit_count  <= 32'd0;
      r_miss_count <= 32'd0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_retry <= 1'b0;
      end else if (w_miss) begin
        r_retry <= 1'b1;
      end
      if (w_hit && !r_retry) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller
// Exercises the read/write instance against a cache-state model and a READ_ONLY instance directly.
module tb_cache_controller;
  localparam int TW = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req_valid, req_write;
  logic [1:0]    req_set;
  logic [TW-1:0] req_tag;
  logic          req_ready, req_done;
  logic          vbm, vdb;
  logic [TW-1:0] sel_tag;
  logic          clr_v, fin, set_d, clr_d, cpu_we, fill_we;
  logic          mrv, mrw, mresp;
  logic [TW-1:0] mtag;
  logic [31:0]   hit_count, miss_count;

  logic          ro_req_valid, ro_req_write, ro_vbm, ro_vdb, ro_resp;
  logic          ro_req_ready, ro_req_done, ro_clr_v, ro_fin, ro_set_d, ro_clr_d;
  logic          ro_cpu_we, ro_fill_we, ro_mrv, ro_mrw;
  logic [TW-1:0] ro_mtag;
  logic [31:0]   ro_hit_count, ro_miss_count;

  int n_cmp = 0;
  int n_err = 0;
  int ro_bad = 0;

  cache_controller #(.SET_SIZE(2), .TAG_SIZE(TW), .READ_ONLY(1'b0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_tag(req_tag), .req_ready(req_ready), .req_done(req_done),
    .valid_block_match(vbm), .valid_dirty_bit(vdb), .selected_tag(sel_tag),
    .clear_selected_valid_bit(clr_v), .finish_new_line_install(fin),
    .set_selected_dirty_bit(set_d), .clear_selected_dirty_bit(clr_d),
    .cpu_data_we(cpu_we), .fill_data_we(fill_we), .mem_req_valid(mrv),
    .mem_req_write(mrw), .mem_req_tag(mtag), .mem_resp_valid(mresp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_controller #(.SET_SIZE(2), .TAG_SIZE(TW), .READ_ONLY(1'b1)) dut_ro (
    .clk(clk), .reset(reset), .req_valid(ro_req_valid), .req_write(ro_req_write),
    .req_tag(req_tag), .req_ready(ro_req_ready), .req_done(ro_req_done),
    .valid_block_match(ro_vbm), .valid_dirty_bit(ro_vdb), .selected_tag(sel_tag),
    .clear_selected_valid_bit(ro_clr_v), .finish_new_line_install(ro_fin),
    .set_selected_dirty_bit(ro_set_d), .clear_selected_dirty_bit(ro_clr_d),
    .cpu_data_we(ro_cpu_we), .fill_data_we(ro_fill_we), .mem_req_valid(ro_mrv),
    .mem_req_write(ro_mrw), .mem_req_tag(ro_mtag), .mem_resp_valid(ro_resp),
    .hit_count(ro_hit_count), .miss_count(ro_miss_count)
  );

  // Metadata block stand-in, driven by the controller's strobes
  logic          m_valid [4];
  logic          m_dirty [4];
  logic [TW-1:0] m_tag   [4];

  assign vbm     = m_valid[req_set] && (m_tag[req_set] == req_tag);
  assign vdb     = m_valid[req_set] && m_dirty[req_set];
  assign sel_tag = m_tag[req_set];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_valid[i] <= 1'b0;
        m_dirty[i] <= 1'b0;
        m_tag[i]   <= '0;
      end
    end else begin
      if (clr_v) m_valid[req_set] <= 1'b0;
      if (clr_d) m_dirty[req_set] <= 1'b0;
      if (fin) begin
        m_valid[req_set] <= 1'b1;
        m_tag[req_set]   <= req_tag;
        m_dirty[req_set] <= 1'b0;
      end
      if (set_d) m_dirty[req_set] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (ro_set_d === 1'b1 || ro_clr_d === 1'b1 || ro_cpu_we === 1'b1) ro_bad++;
  end

  // Reference cache state: what each set should hold after each completed request
  bit            r_valid [4];
  bit            r_dirty [4];
  logic [TW-1:0] r_tag   [4];
  int            exp_hits, exp_misses;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", name, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 4; i++) begin
      r_valid[i] = 1'b0;
      r_dirty[i] = 1'b0;
      r_tag[i]   = '0;
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic check_counters(input string name);
`ifdef CACHE_CTRL_PERF_CNT_EN
    check({name, "_hits"}, hit_count, exp_hits);
    check({name, "_misses"}, miss_count, exp_misses);
`else
    check({name, "_hits"}, hit_count, 0);
    check({name, "_misses"}, miss_count, 0);
`endif
  endtask

  task automatic do_req(input logic [1:0] set, input logic [TW-1:0] tag, input bit wr,
                        input int d_wb, input int d_fill);
    bit            hit, dmiss;
    logic [TW-1:0] victim;
    int exp_done, cyc, wait_cnt, done_cyc;
    int wb_cyc, fill_cyc, n_bad_tag, n_ready, n_both;
    int n_setd, n_cpuwe, n_clrd, n_clrv, n_fillwe, n_fin, n_done_side;
    hit      = r_valid[set] && (r_tag[set] == tag);
    dmiss    = !hit && r_valid[set] && r_dirty[set];
    victim   = r_tag[set];
    exp_done = hit ? 1 : (dmiss ? d_wb + d_fill + 4 : d_fill + 3);
    {cyc, wait_cnt, done_cyc, wb_cyc, fill_cyc, n_bad_tag, n_ready, n_both} = '0;
    {n_setd, n_cpuwe, n_clrd, n_clrv, n_fillwe, n_fin, n_done_side} = '0;

    @(negedge clk);
    req_valid = 1'b1;
    req_set   = set;
    req_tag   = tag;
    req_write = wr;
    mresp     = 1'b0;
    #1 check("accept_ready", req_ready, 1);
    @(posedge clk);

    while (done_cyc == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      mresp = 1'b0;
      if (mrv === 1'b1) begin
        if (wait_cnt == (mrw ? d_wb : d_fill)) begin
          mresp    = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      #1;
      if (mrv === 1'b1 && mrw === 1'b1) begin wb_cyc++;   if (mtag !== victim) n_bad_tag++; end
      if (mrv === 1'b1 && mrw === 1'b0) begin fill_cyc++; if (mtag !== tag)    n_bad_tag++; end
      if (req_ready !== 1'b0) n_ready++;
      if (clr_v === 1'b1 && fin === 1'b1) n_both++;
      if (set_d === 1'b1)   n_setd++;
      if (cpu_we === 1'b1)  n_cpuwe++;
      if (clr_d === 1'b1)   n_clrd++;
      if (clr_v === 1'b1)   n_clrv++;
      if (fill_we === 1'b1) n_fillwe++;
      if (fin === 1'b1)     n_fin++;
      if ((set_d === 1'b1 || cpu_we === 1'b1) && req_done !== 1'b1) n_done_side++;
      if (req_done === 1'b1) done_cyc = cyc;
    end
    mresp = 1'b0;

    check("done_cycle", done_cyc, exp_done);
    check("wb_cycles", wb_cyc, dmiss ? d_wb + 1 : 0);
    check("fill_cycles", fill_cyc, hit ? 0 : d_fill + 1);
    check("mem_tag_errors", n_bad_tag, 0);
    check("ready_while_busy", n_ready, 0);
    check("clr_valid_with_install", n_both, 0);
    check("set_dirty_pulses", n_setd, wr ? 1 : 0);
    check("cpu_we_pulses", n_cpuwe, wr ? 1 : 0);
    check("store_strobe_without_done", n_done_side, 0);
    check("clr_dirty_pulses", n_clrd, dmiss ? 1 : 0);
    check("clr_valid_pulses", n_clrv, dmiss ? 1 : 0);
    check("fill_we_pulses", n_fillwe, hit ? 0 : 1);
    check("install_pulses", n_fin, hit ? 0 : 1);

    if (hit) begin
      exp_hits++;
      if (wr) r_dirty[set] = 1'b1;
    end else begin
      exp_misses++;
      r_valid[set] = 1'b1;
      r_tag[set]   = tag;
      r_dirty[set] = wr;
    end
    check_counters("counters");
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_set      = 2'd0;
    req_tag      = '0;
    mresp        = 1'b0;
    ro_req_valid = 1'b0;
    ro_req_write = 1'b0;
    ro_vbm       = 1'b0;
    ro_vdb       = 1'b0;
    ro_resp      = 1'b0;
    ref_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_req_done", req_done, 0);
    check("rst_mem_req_valid", mrv, 0);
    check("rst_mem_req_write", mrw, 0);
    check("rst_mem_req_tag", mtag, 0);
    check("rst_strobes", {clr_v, fin, set_d, clr_d, cpu_we, fill_we}, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);

    do_req(2'd1, 30'h5, 1'b0, 0, 3);
    do_req(2'd1, 30'h5, 1'b0, 0, 0);
    do_req(2'd1, 30'h5, 1'b1, 0, 0);
    do_req(2'd1, 30'h9, 1'b0, 2, 1);
    do_req(2'd1, 30'h9, 1'b1, 0, 0);
    do_req(2'd1, 30'h5, 1'b0, 0, 0);

    // Reset while the fill is outstanding
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = 2'd2;
    req_tag   = 30'h7;
    req_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("mid_fill_req_valid", mrv, 1);
    reset     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_mem_req_valid", mrv, 0);
    check("post_reset_req_ready", req_ready, 1);
    check("post_reset_hit_count", hit_count, 0);
    check("post_reset_miss_count", miss_count, 0);
    reset = 1'b0;
    ref_reset();

    for (int k = 0; k < 40; k++) begin
      do_req(2'($urandom_range(0, 3)), 30'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 4), $urandom_range(0, 4));
    end
    @(negedge clk);
    req_valid = 1'b0;

    // READ_ONLY instance: a store hit completes without dirty or data-write strobes
    @(negedge clk);
    #1 check("ro_idle_ready", ro_req_ready, 1);
    ro_req_valid = 1'b1;
    ro_req_write = 1'b1;
    ro_vbm       = 1'b1;
    ro_vdb       = 1'b0;
    @(negedge clk);
    #1;
    check("ro_hit_done", ro_req_done, 1);
    check("ro_hit_cpu_we", ro_cpu_we, 0);
    check("ro_hit_set_dirty", ro_set_d, 0);
    @(negedge clk);
    ro_req_valid = 1'b0;

    // A dirty-flagged miss still goes straight to a fill
    @(negedge clk);
    ro_req_valid = 1'b1;
    ro_req_write = 1'b1;
    ro_vbm       = 1'b0;
    ro_vdb       = 1'b1;
    @(negedge clk);
    #1 check("ro_miss_no_done", ro_req_done, 0);
    @(negedge clk);
    #1;
    check("ro_fill_valid", ro_mrv, 1);
    check("ro_fill_write", ro_mrw, 0);
    ro_resp = 1'b1;
    #1;
    check("ro_fill_we", ro_fill_we, 1);
    check("ro_no_clr_valid", ro_clr_v, 0);
    @(negedge clk);
    ro_resp = 1'b0;
    ro_vbm  = 1'b1;
    #1;
    check("ro_relookup_done", ro_req_done, 1);
    @(negedge clk);
    ro_req_valid = 1'b0;
    #1;
    check("ro_dirty_or_we_strobes", ro_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
